bcd_digit_scanner: RTL
======================

BCD_DIGIT_SCANNER -- requirements
Module: bcd_digit_scanner

Interface
REQ-001 The block SHALL have a parameter PRESCALE, default 1000, giving the clock cycles per digit slot; legal range 2..65535.
REQ-002 The block SHALL have a parameter BLANK, default 8, giving the anode-off dead-time cycles at the start of each slot; legal range 1..PRESCALE-1.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset: synchronous, active-high.
REQ-005 EN  input  1  scan enable; 0 freezes the scan and blanks the display.
REQ-006 LZB  input  1  leading-zero blanking enable.
REQ-007 D0, D1, D2, D3  input  4 each  BCD digits; D0 is least significant, D3 most significant.
REQ-008 W, X, Y, Z  output  1 each  BCD code of the current digit for the downstream seven-segment decoder; W is MSB, Z is LSB.
REQ-009 AN  output  4  active-low digit anodes; AN[i] drives digit i.
REQ-010 DIG  output  2  index of the current digit slot.
REQ-011 FRAME  output  1  one-cycle pulse marking the start of each new scan frame.

Function
REQ-012 All outputs SHALL be decoded from registers only, with no combinational path from any input to any output.
REQ-013 The FSM SHALL have three states, IDLE, BLANK and DRIVE, plus a slot counter CNT (0..PRESCALE-1) and the DIG register.
REQ-014 In IDLE, when EN=1 the FSM SHALL go to BLANK with CNT=0, keeping DIG unchanged; otherwise it SHALL stay in IDLE.
REQ-015 In BLANK, CNT SHALL increment each cycle, and the FSM SHALL enter DRIVE when CNT reaches BLANK-1.
REQ-016 In DRIVE, CNT SHALL increment each cycle; at CNT=PRESCALE-1, CNT SHALL become 0, DIG SHALL become (DIG+1) mod 4 (3 wraps to 0), and the FSM SHALL enter BLANK.
REQ-017 EN=0 in BLANK or DRIVE SHALL move the FSM to IDLE on the next edge, holding DIG and CNT; on resume, the held digit's slot restarts at BLANK with CNT=0.
REQ-018 Every entry into BLANK with (new) DIG=0 SHALL load snapshot registers S0..S3 from D0..D3, so that a whole frame displays one coherent value.
REQ-019 A change on D0..D3 at any other time SHALL NOT affect the outputs until the next snapshot.
REQ-020 {W,X,Y,Z} SHALL equal S[DIG] in every state, including IDLE and BLANK.
REQ-021 AN SHALL be 4'b1111 in IDLE and BLANK.
REQ-022 In DRIVE, AN[DIG] SHALL be 0 and all other AN bits 1, unless digit DIG is suppressed.
REQ-023 Digit i SHALL be suppressed when S[i] > 9 (invalid BCD).
REQ-024 Digit i SHALL also be suppressed when LZB=1, i>=1, and S[i] and every S[j] with j>i are all 0.
REQ-025 Digit 0 SHALL never be suppressed by LZB.
REQ-026 LZB SHALL be sampled into a register together with the snapshot.
REQ-027 FRAME SHALL be 1 for exactly the first cycle of each BLANK entered with DIG=0, whether from DRIVE (wrap) or from IDLE, and 0 at all other times.
REQ-028 Slot period SHALL be exactly PRESCALE cycles, the anode-on time exactly PRESCALE-BLANK cycles, and a full frame exactly 4*PRESCALE cycles while EN stays 1.

Reset
REQ-029 RST=1 SHALL set state=IDLE, CNT=0, DIG=0, S0..S3=0, LZB register=0, AN=4'b1111, {W,X,Y,Z}=0000 and FRAME=0.
REQ-030 RST SHALL take priority over EN and over any FSM transition, including mid-slot.
REQ-031 With EN=1 after reset release, the first edge SHALL enter BLANK with DIG=0, take a snapshot and pulse FRAME.

Verification (PRESCALE=8, BLANK=2)
REQ-032 Scenario: reset, then EN=1, D3..D0=1,2,3,4, LZB=0 -> FRAME pulses 1 cycle; AN=1111 for 2 cycles then 1110 for 6 cycles with WXYZ=0100; then AN=1101 with WXYZ=0011, and so on; FRAME repeats every 32 cycles.
REQ-033 Scenario: D3..D0=0,0,7,0 with LZB=1 -> digits 3 and 2 stay dark (AN=1111 during their DRIVE); digit 1 lights with 0111; digit 0 lights with 0000.
REQ-034 Scenario: D2=4'hC -> the digit-2 slot shows AN=1111 throughout while WXYZ=1100; the other digits are unaffected.
REQ-035 Scenario: D0 changed mid-frame -> outputs keep the old value until the next FRAME pulse, then show the new value.
REQ-036 Scenario: EN dropped during the DRIVE of digit 2 -> AN=1111 on the next cycle and DIG stays 2; EN raised again -> 2 blank cycles, then digit 2 is driven for a full 6 cycles.
REQ-037 Scenario: RST asserted mid-DRIVE of digit 3 -> the next cycle shows the REQ-029 values; after release, the scan restarts at digit 0 with FRAME pulsed.

Source files
------------

// File: rtl/bcd_digit_scanner.sv
// Time-multiplexed four-digit BCD display scanner with per-slot anode dead time,
// frame-coherent digit snapshots, leading-zero blanking and invalid-digit suppression.
module bcd_digit_scanner #(
   parameter int PRESCALE = 1000,
   parameter int BLANK    = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic       LZB,
   input  logic [3:0] D0,
   input  logic [3:0] D1,
   input  logic [3:0] D2,
   input  logic [3:0] D3,
   output logic       W,
   output logic       X,
   output logic       Y,
   output logic       Z,
   output logic [3:0] AN,
   output logic [1:0] DIG,
   output logic       FRAME
);

   localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    dig;
   logic [3:0]    snap [4];
   logic          lzb_s;
   logic          frame_r;
   logic          take_snap;
   logic          hz1, hz2, hz3;
   logic [3:0]    supp;
   logic [3:0]    cur;

   // A snapshot is taken on every entry into BLANK whose digit will be 0:
   // either resuming from IDLE on digit 0 or wrapping from digit 3.
   assign take_snap = EN && (((state == ST_IDLE) && (dig == 2'd0)) ||
                             ((state == ST_DRIVE) && (cnt == CNT_LAST) && (dig == 2'd3)));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         dig     <= 2'd0;
         snap[0] <= 4'd0;
         snap[1] <= 4'd0;
         snap[2] <= 4'd0;
         snap[3] <= 4'd0;
         lzb_s   <= 1'b0;
         frame_r <= 1'b0;
      end else begin
         frame_r <= take_snap;
         if (take_snap) begin
            snap[0] <= D0;
            snap[1] <= D1;
            snap[2] <= D2;
            snap[3] <= D3;
            lzb_s   <= LZB;
         end
         case (state)
            ST_IDLE: begin
               if (EN) begin
                  state <= ST_BLANK;
                  cnt   <= '0;
               end
            end
            ST_BLANK: begin
               if (!EN) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (cnt == BLANK_LAST) state <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (!EN) begin
                  state <= ST_IDLE;
               end else if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  dig   <= dig + 2'd1;
                  state <= ST_BLANK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // hzN: snapshot digits N..3 are all zero, i.e. digit N is a leading zero.
   assign hz3 = (snap[3] == 4'd0);
   assign hz2 = hz3 && (snap[2] == 4'd0);
   assign hz1 = hz2 && (snap[1] == 4'd0);

   assign supp[0] = (snap[0] > 4'd9);
   assign supp[1] = (snap[1] > 4'd9) || (lzb_s && hz1);
   assign supp[2] = (snap[2] > 4'd9) || (lzb_s && hz2);
   assign supp[3] = (snap[3] > 4'd9) || (lzb_s && hz3);

   assign cur          = snap[dig];
   assign {W, X, Y, Z} = cur;
   assign DIG          = dig;
   assign FRAME        = frame_r;
   assign AN           = ((state == ST_DRIVE) && !supp[dig]) ? ~(4'b0001 << dig) : 4'b1111;

endmodule
